// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, FSM state encodings, timeout default and the
// latched command payload for the load/store responder.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned WEN_W = 4;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned TMO_W = 16;

  // FSM state encodings
  localparam logic [ST_W-1:0] CIRNO_LSU_ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] CIRNO_LSU_ST_CMD  = 2'd1;
  localparam logic [ST_W-1:0] CIRNO_LSU_ST_RSP  = 2'd2;
  localparam logic [ST_W-1:0] CIRNO_LSU_ST_ACK  = 2'd3;

  localparam int unsigned CIRNO_LSU_TIMEOUT_DFLT = 255;

  // Request as presented on the bus command channel
  typedef struct packed {
    logic [XLEN-1:0]  adr;
    logic [XLEN-1:0]  wdat;
    logic [WEN_W-1:0] wen;
    logic             read;
  } lsu_cmd_t;

  // Word-align a byte address
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] adr);
    return adr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/lsu_tmo.sv
// lsu_tmo: transaction watchdog for lsu (present only with CIRNO_LSU_TIMEOUT_EN).
//   clk, rst_n      clock, async active-low reset
//   start_i         transaction enters CMD this cycle (clears counter)
//   active_i        transaction currently in CMD or RSP
//   set_drop_i      a timed-out command still owes a bus response
//   rsp_hs_i        response handshake on the bus this cycle
//   expire_c_o      counter at TIMEOUT_CYC-1 while active (combinational)
//   drop_nxt_c_o    next value of drop_pend (combinational)
`ifdef CIRNO_LSU_TIMEOUT_EN
module lsu_tmo
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = CIRNO_LSU_TIMEOUT_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic active_i,
  input  logic set_drop_i,
  input  logic rsp_hs_i,
  output logic expire_c_o,
  output logic drop_nxt_c_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             drop_pend_q, drop_pend_d;

  // Expiry looks only at registered count so it never loops back through start_i
  assign expire_c_o   = active_i && (cnt_q == TMO_LAST);
  assign drop_nxt_c_o = drop_pend_d;

  // Counter and pending-drop next state
  always_comb begin
    cnt_d       = cnt_q;
    drop_pend_d = drop_pend_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
    // The owed response is swallowed by whichever handshake comes first
    if (drop_pend_q && rsp_hs_i) begin
      drop_pend_d = 1'b0;
    end
    if (set_drop_i) begin
      drop_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      drop_pend_q <= drop_pend_d;
    end
  end

endmodule
`endif

// File: rtl/lsu.sv
// lsu: load/store responder between the execute unit and the data-side bus.
// Takes one request over hs_ex4ls_val, issues it as a single bus command,
// waits for the response and returns it with a one-cycle hs_ls4ex_rdy pulse.
// Optional watchdog: define CIRNO_LSU_TIMEOUT_EN to enable the TIMEOUT_CYC
// forced-error completion and late-response discard.
//   hs_ex4ls_val / hs_ls4ex_rdy   ex-side request valid / completion pulse
//   i_ls_adr/wdat/wen/ren         request fields (held stable while valid)
//   o_ls_rdat / o_ls_err          result, meaningful while hs_ls4ex_rdy
//   o_bus_cmd_val / i_bus_cmd_rdy bus command handshake
//   o_bus_adr/wdat/wen/read       bus command fields
//   i_bus_rsp_val / o_bus_rsp_rdy bus response handshake
//   i_bus_rsp_dat / i_bus_rsp_err bus response payload
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = CIRNO_LSU_TIMEOUT_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_ex4ls_val,
  output logic             hs_ls4ex_rdy,
  input  logic [XLEN-1:0]  i_ls_adr,
  input  logic [XLEN-1:0]  i_ls_wdat,
  input  logic [WEN_W-1:0] i_ls_wen,
  input  logic             i_ls_ren,
  output logic [XLEN-1:0]  o_ls_rdat,
  output logic             o_ls_err,
  output logic             o_bus_cmd_val,
  input  logic             i_bus_cmd_rdy,
  output logic [XLEN-1:0]  o_bus_adr,
  output logic [XLEN-1:0]  o_bus_wdat,
  output logic [WEN_W-1:0] o_bus_wen,
  output logic             o_bus_read,
  input  logic             i_bus_rsp_val,
  output logic             o_bus_rsp_rdy,
  input  logic [XLEN-1:0]  i_bus_rsp_dat,
  input  logic             i_bus_rsp_err
);

  // Reject out-of-range timeout at elaboration
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_tmo_range
    $error("lsu: TIMEOUT_CYC must be within 2..65535");
  end

  logic [ST_W-1:0]  state_q, state_d;
  lsu_cmd_t         req_q, req_d;
  logic [XLEN-1:0]  rdat_q, rdat_d;
  logic             err_q, err_d;
  logic             cmd_val_q, cmd_val_d;
  logic             rsp_rdy_q, rsp_rdy_d;
  logic             ls_rdy_q, ls_rdy_d;

  logic             cmd_hs;
  logic             rsp_hs;

  assign cmd_hs = cmd_val_q && i_bus_cmd_rdy;
  assign rsp_hs = i_bus_rsp_val && rsp_rdy_q;

`ifdef CIRNO_LSU_TIMEOUT_EN
  logic tmo_start;
  logic tmo_active;
  logic tmo_expire;
  logic set_drop;
  logic drop_nxt;

  assign tmo_start  = (state_d == CIRNO_LSU_ST_CMD) && (state_q != CIRNO_LSU_ST_CMD);
  assign tmo_active = (state_q == CIRNO_LSU_ST_CMD) || (state_q == CIRNO_LSU_ST_RSP);

  lsu_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (tmo_start),
    .active_i     (tmo_active),
    .set_drop_i   (set_drop),
    .rsp_hs_i     (rsp_hs),
    .expire_c_o   (tmo_expire),
    .drop_nxt_c_o (drop_nxt)
  );
`endif

  // FSM next state and capture registers
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
`ifdef CIRNO_LSU_TIMEOUT_EN
    set_drop = 1'b0;
`endif
    case (state_q)
      CIRNO_LSU_ST_IDLE: begin
        if (hs_ex4ls_val) begin
          req_d.adr  = word_align(i_ls_adr);
          req_d.wdat = i_ls_wdat;
          req_d.wen  = i_ls_wen;
          // Any byte enable makes it a store; ren only matters when wen is 0
          req_d.read = (i_ls_wen == '0) && i_ls_ren;
          rdat_d     = '0;
          err_d      = 1'b0;
          if ((i_ls_wen != '0) || i_ls_ren) begin
            state_d = CIRNO_LSU_ST_CMD;
          end else begin
            state_d = CIRNO_LSU_ST_ACK;
          end
        end
      end
      CIRNO_LSU_ST_CMD: begin
        if (cmd_hs) begin
          state_d = CIRNO_LSU_ST_RSP;
        end
`ifdef CIRNO_LSU_TIMEOUT_EN
        // A command accepted on the expiry cycle still owes a response
        if (tmo_expire) begin
          state_d  = CIRNO_LSU_ST_ACK;
          rdat_d   = '0;
          err_d    = 1'b1;
          set_drop = cmd_hs;
        end
`endif
      end
      CIRNO_LSU_ST_RSP: begin
        if (rsp_hs) begin
          state_d = CIRNO_LSU_ST_ACK;
          rdat_d  = req_q.read ? i_bus_rsp_dat : '0;
          err_d   = i_bus_rsp_err;
        end
`ifdef CIRNO_LSU_TIMEOUT_EN
        else if (tmo_expire) begin
          state_d  = CIRNO_LSU_ST_ACK;
          rdat_d   = '0;
          err_d    = 1'b1;
          set_drop = 1'b1;
        end
`endif
      end
      CIRNO_LSU_ST_ACK: begin
        state_d = CIRNO_LSU_ST_IDLE;
      end
      default: begin
        state_d = CIRNO_LSU_ST_IDLE;
      end
    endcase
  end

  // Registered handshake outputs derived from the next state
  always_comb begin
    cmd_val_d = (state_d == CIRNO_LSU_ST_CMD);
    rsp_rdy_d = (state_d == CIRNO_LSU_ST_RSP);
    ls_rdy_d  = (state_d == CIRNO_LSU_ST_ACK);
`ifdef CIRNO_LSU_TIMEOUT_EN
    // Hold the new command back until the abandoned response has drained
    cmd_val_d = cmd_val_d && !drop_nxt;
    rsp_rdy_d = rsp_rdy_d || drop_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CIRNO_LSU_ST_IDLE;
      req_q     <= '0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
      cmd_val_q <= 1'b0;
      rsp_rdy_q <= 1'b0;
      ls_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
      cmd_val_q <= cmd_val_d;
      rsp_rdy_q <= rsp_rdy_d;
      ls_rdy_q  <= ls_rdy_d;
    end
  end

  assign hs_ls4ex_rdy  = ls_rdy_q;
  assign o_ls_rdat     = rdat_q;
  assign o_ls_err      = err_q;
  assign o_bus_cmd_val = cmd_val_q;
  assign o_bus_rsp_rdy = rsp_rdy_q;
  assign o_bus_adr     = req_q.adr;
  assign o_bus_wdat    = req_q.wdat;
  assign o_bus_wen     = req_q.wen;
  assign o_bus_read    = req_q.read;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        hs_ex4ls_val;
  logic        hs_ls4ex_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_bus_cmd_val;
  logic        i_bus_cmd_rdy;
  logic [31:0] o_bus_adr;
  logic [31:0] o_bus_wdat;
  logic [3:0]  o_bus_wen;
  logic        o_bus_read;
  logic        i_bus_rsp_val;
  logic        o_bus_rsp_rdy;
  logic [31:0] i_bus_rsp_dat;
  logic        i_bus_rsp_err;

  lsu #(.TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs_ex4ls_val  (hs_ex4ls_val),
    .hs_ls4ex_rdy  (hs_ls4ex_rdy),
    .i_ls_adr      (i_ls_adr),
    .i_ls_wdat     (i_ls_wdat),
    .i_ls_wen      (i_ls_wen),
    .i_ls_ren      (i_ls_ren),
    .o_ls_rdat     (o_ls_rdat),
    .o_ls_err      (o_ls_err),
    .o_bus_cmd_val (o_bus_cmd_val),
    .i_bus_cmd_rdy (i_bus_cmd_rdy),
    .o_bus_adr     (o_bus_adr),
    .o_bus_wdat    (o_bus_wdat),
    .o_bus_wen     (o_bus_wen),
    .o_bus_read    (o_bus_read),
    .i_bus_rsp_val (i_bus_rsp_val),
    .o_bus_rsp_rdy (o_bus_rsp_rdy),
    .i_bus_rsp_dat (i_bus_rsp_dat),
    .i_bus_rsp_err (i_bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic        ren;
    int          cw;        // cycles cmd_rdy stays low while cmd_val is high
    int          rw;        // extra cycles after cmd accept before rsp_val
    logic [31:0] bdat;
    logic        berr;
    int          late_at;   // cycle to present a stale response (0 = none)
    logic [31:0] late_dat;
    logic        exp_cmd;
    logic [31:0] exp_adr;
    logic [3:0]  exp_wen;
    logic        exp_read;
    int          exp_lat;
    logic [31:0] exp_rdat;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [3:0] wen, input logic ren,
                              input int cw, input int rw,
                              input logic [31:0] bdat, input logic berr,
                              input int late_at, input logic [31:0] late_dat,
                              input logic exp_cmd, input logic [31:0] exp_adr,
                              input logic [3:0] exp_wen, input logic exp_read,
                              input int exp_lat, input logic [31:0] exp_rdat,
                              input logic exp_err);
    vec_t v;
    v.adr = adr; v.wdat = wdat; v.wen = wen; v.ren = ren;
    v.cw = cw; v.rw = rw; v.bdat = bdat; v.berr = berr;
    v.late_at = late_at; v.late_dat = late_dat;
    v.exp_cmd = exp_cmd; v.exp_adr = exp_adr; v.exp_wen = exp_wen;
    v.exp_read = exp_read; v.exp_lat = exp_lat; v.exp_rdat = exp_rdat;
    v.exp_err = exp_err;
    return v;
  endfunction

  // Drive one request (at a negedge) and act as the bus until completion
  task automatic run_vec(input vec_t v, input string tag);
    int          ta;
    int          cmd_cnt;
    int          ncmd;
    int          lat;
    bit          got_rdy;
    bit          seen;
    bit          unstable;
    bit          stray;
    bit          early_cmd;
    bit          rsp_done;
    bit          late_done;
    bit          late_prev;
    logic [31:0] s_adr;
    logic [31:0] s_wdat;
    logic [3:0]  s_wen;
    logic        s_read;
    ta = -1; cmd_cnt = 0; ncmd = 0; lat = 999;
    got_rdy = 0; seen = 0; unstable = 0; stray = 0; early_cmd = 0;
    rsp_done = 0; late_done = 0;
    s_adr = '0; s_wdat = '0; s_wen = '0; s_read = 1'b0;
    hs_ex4ls_val = 1'b1;
    i_ls_adr     = v.adr;
    i_ls_wdat    = v.wdat;
    i_ls_wen     = v.wen;
    i_ls_ren     = v.ren;
    for (int t = 1; t <= 40 && !got_rdy; t++) begin
      @(negedge clk);
      late_prev     = late_done;
      i_bus_rsp_val = 1'b0;
      i_bus_rsp_dat = '0;
      i_bus_rsp_err = 1'b0;
      if (v.late_at != 0 && !late_done && t >= v.late_at) begin
        i_bus_rsp_val = 1'b1;
        i_bus_rsp_dat = v.late_dat;
        if (o_bus_rsp_rdy) late_done = 1;
      end else if (ta >= 0 && !rsp_done && t >= ta + 1 + v.rw) begin
        i_bus_rsp_val = 1'b1;
        i_bus_rsp_dat = v.bdat;
        i_bus_rsp_err = v.berr;
        if (o_bus_rsp_rdy) rsp_done = 1;
      end
      if (o_bus_rsp_rdy && ta < 0 && v.late_at == 0) stray = 1;
      i_bus_cmd_rdy = 1'b0;
      if (o_bus_cmd_val) begin
        ncmd++;
        if (v.late_at != 0 && !late_prev) early_cmd = 1;
        if (!seen) begin
          seen = 1;
          s_adr = o_bus_adr; s_wdat = o_bus_wdat; s_wen = o_bus_wen; s_read = o_bus_read;
        end else if ({o_bus_adr, o_bus_wdat, o_bus_wen, o_bus_read} !==
                     {s_adr, s_wdat, s_wen, s_read}) begin
          unstable = 1;
        end
        if (ta < 0 && cmd_cnt >= v.cw) begin
          i_bus_cmd_rdy = 1'b1;
          ta = t;
        end
        cmd_cnt++;
      end
      if (hs_ls4ex_rdy) begin
        got_rdy = 1;
        lat = t;
        chk({tag, " rdat"}, o_ls_rdat, v.exp_rdat);
        chk({tag, " err"}, 32'(o_ls_err), 32'(v.exp_err));
        hs_ex4ls_val = 1'b0;
      end
    end
    chk({tag, " rdy latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " cmd cycles"}, 32'(ncmd), v.exp_cmd ? 32'(v.cw + 1) : 32'd0);
    if (v.exp_cmd && seen) begin
      chk({tag, " bus adr"}, s_adr, v.exp_adr);
      chk({tag, " bus wdat"}, s_wdat, v.wdat);
      chk({tag, " bus wen"}, 32'(s_wen), 32'(v.exp_wen));
      chk({tag, " bus read"}, 32'(s_read), 32'(v.exp_read));
      chk({tag, " cmd stable"}, 32'(unstable), 32'd0);
    end
    if (v.late_at == 0) chk({tag, " stray rsp_rdy"}, 32'(stray), 32'd0);
    else                chk({tag, " cmd before drop"}, 32'(early_cmd), 32'd0);
    hs_ex4ls_val = 1'b0;
    @(negedge clk);
    i_bus_cmd_rdy = 1'b0;
    i_bus_rsp_val = 1'b0;
    i_bus_rsp_dat = '0;
    i_bus_rsp_err = 1'b0;
    chk({tag, " single rdy pulse"}, 32'(hs_ls4ex_rdy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rdy"}, 32'(hs_ls4ex_rdy), 32'd0);
    chk({tag, " rdat"}, o_ls_rdat, 32'd0);
    chk({tag, " err"}, 32'(o_ls_err), 32'd0);
    chk({tag, " cmd_val"}, 32'(o_bus_cmd_val), 32'd0);
    chk({tag, " rsp_rdy"}, 32'(o_bus_rsp_rdy), 32'd0);
    chk({tag, " bus adr"}, o_bus_adr, 32'd0);
    chk({tag, " bus wdat"}, o_bus_wdat, 32'd0);
    chk({tag, " bus wen"}, 32'(o_bus_wen), 32'd0);
    chk({tag, " bus read"}, 32'(o_bus_read), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    //           adr           wdat          wen    ren cw rw bdat          berr late late_dat     cmd exp_adr       wen    rd lat rdat          err
    vecs.push_back(mk(32'h8000_0006, 32'h1122_3344, 4'b1100, 1'b0, 0, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0,
                      1'b1, 32'h8000_0004, 4'b1100, 1'b0, 3, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(32'h0000_0100, 32'h0000_0000, 4'b0000, 1'b1, 2, 2, 32'hCAFE_BABE, 1'b0, 0, 32'h0,
                      1'b1, 32'h0000_0100, 4'b0000, 1'b1, 7, 32'hCAFE_BABE, 1'b0));
    vecs.push_back(mk(32'h0000_0207, 32'h0000_0000, 4'b0000, 1'b1, 0, 1, 32'h1234_5678, 1'b1, 0, 32'h0,
                      1'b1, 32'h0000_0204, 4'b0000, 1'b1, 4, 32'h1234_5678, 1'b1));
    vecs.push_back(mk(32'h0000_0208, 32'h0000_0000, 4'b0000, 1'b1, 1, 0, 32'h0BAD_F00D, 1'b0, 0, 32'h0,
                      1'b1, 32'h0000_0208, 4'b0000, 1'b1, 4, 32'h0BAD_F00D, 1'b0));
    vecs.push_back(mk(32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 0, 32'h0,
                      1'b0, 32'h0000_0000, 4'b0000, 1'b0, 1, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(32'h0000_0003, 32'hA5A5_A5A5, 4'b0001, 1'b1, 0, 0, 32'h7777_7777, 1'b1, 0, 32'h0,
                      1'b1, 32'h0000_0000, 4'b0001, 1'b0, 3, 32'h0000_0000, 1'b1));
`ifdef CIRNO_LSU_TIMEOUT_EN
    // Response never arrives: forced error at cycle 9 with TIMEOUT_CYC=8
    vecs.push_back(mk(32'h0000_0300, 32'h0000_0000, 4'b0000, 1'b1, 0, 1000, 32'h0000_0000, 1'b0, 0, 32'h0,
                      1'b1, 32'h0000_0300, 4'b0000, 1'b1, 9, 32'h0000_0000, 1'b1));
    // Stale response at cycle 2 is discarded before the new command goes out
    vecs.push_back(mk(32'h0000_0304, 32'h0000_0000, 4'b0000, 1'b1, 0, 0, 32'h0000_00A5, 1'b0, 2, 32'hDEAD_0001,
                      1'b1, 32'h0000_0304, 4'b0000, 1'b1, 5, 32'h0000_00A5, 1'b0));
`endif

    rst_n         = 1'b0;
    hs_ex4ls_val  = 1'b0;
    i_ls_adr      = '0;
    i_ls_wdat     = '0;
    i_ls_wen      = '0;
    i_ls_ren      = 1'b0;
    i_bus_cmd_rdy = 1'b0;
    i_bus_rsp_val = 1'b0;
    i_bus_rsp_dat = '0;
    i_bus_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while waiting in RSP, then a fresh load
    hs_ex4ls_val = 1'b1;
    i_ls_adr     = 32'h0000_0040;
    i_ls_wdat    = '0;
    i_ls_wen     = 4'b0000;
    i_ls_ren     = 1'b1;
    @(negedge clk);
    chk("midrst cmd_val", 32'(o_bus_cmd_val), 32'd1);
    i_bus_cmd_rdy = 1'b1;
    @(negedge clk);
    chk("midrst rsp_rdy", 32'(o_bus_rsp_rdy), 32'd1);
    i_bus_cmd_rdy = 1'b0;
    hs_ex4ls_val  = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(32'h0000_0044, 32'h0000_0000, 4'b0000, 1'b1, 0, 0, 32'h5A5A_5A5A, 1'b0, 0, 32'h0,
               1'b1, 32'h0000_0044, 4'b0000, 1'b1, 3, 32'h5A5A_5A5A, 1'b0), "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store responder for the execute unit's memory port. Accepts one AGU-originated request at a time over the ex↔ls valid/ready handshake and registers it. Issues it as a single command on the core's data-bus command/response channels, then returns the raw read word (or store completion) to the execute unit. Sits between the execute unit and the data-side bus/SRAM bridge.

## Interface
- TIMEOUT_CYC, 255: cycles a transaction may spend in CMD+RSP before forced error completion (only with CIRNO_LSU_TIMEOUT_EN); legal 2..65535.
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hs_ex4ls_val  in  1  request valid; held with fields stable until hs_ls4ex_rdy
- hs_ls4ex_rdy  out  1  one-cycle completion pulse
- i_ls_adr  in  32  byte address
- i_ls_wdat  in  32  store data, lane-aligned
- i_ls_wen  in  4  byte write enables; nonzero = store
- i_ls_ren  in  1  load request
- o_ls_rdat  out  32  load word, valid only while hs_ls4ex_rdy
- o_ls_err  out  1  bus error/timeout, valid only while hs_ls4ex_rdy
- o_bus_cmd_val / i_bus_cmd_rdy  out/in  1  command handshake
- o_bus_adr  out  32  {adr[31:2],2'b00}
- o_bus_wdat  out  32  store data
- o_bus_wen  out  4  byte enables (0 for load)
- o_bus_read  out  1  1 = load command
- i_bus_rsp_val / o_bus_rsp_rdy  in/out  1  response handshake
- i_bus_rsp_dat  in  32  load data
- i_bus_rsp_err  in  1  bus error

## Operation
- FSM: IDLE, CMD, RSP, ACK.
- IDLE: on hs_ex4ls_val, latch adr/wdat/wen/ren. wen≠0 → CMD as store (ren ignored). wen=0, ren=1 → CMD as load. Neither → ACK, no bus command, rdat 0, err 0.
- CMD: o_bus_cmd_val=1 with latched fields; on i_bus_cmd_rdy → RSP. Fields never change while cmd_val high.
- RSP: o_bus_rsp_rdy=1; on i_bus_rsp_val capture dat (loads; stores capture 0) and err → ACK.
- ACK: hs_ls4ex_rdy=1, o_ls_rdat/o_ls_err from capture registers → IDLE. Request not re-sampled in ACK.
- One outstanding transaction; all ex-side outputs registered (no combinational bus→ex path).

## Timing
- Reset: state IDLE; all outputs 0; capture registers 0; drop_pend 0; timeout counter 0.
- Zero-wait bus: val cycle 0 → cmd_val cycle 1 → rsp accepted cycle 2 → rdy cycle 3. No-op: rdy cycle 1.
- Back-to-back: next request accepted earliest the cycle after ACK (one bubble).
- rsp_val while not in RSP is not accepted (rsp_rdy=0), except drop case below.
- Reset asserted mid-transaction: immediate return to IDLE, outputs 0; bus side must be reset together.

## Configuration
- CIRNO_LSU_TIMEOUT_EN defined: counter clears on entering CMD and increments each cycle in CMD/RSP. When it equals TIMEOUT_CYC-1 with no completion that cycle → ACK with err=1, rdat 0. Completion in the same cycle as expiry wins (normal result). Timeout in CMD drops cmd_val. Timeout in RSP sets drop_pend: the next response is accepted (rsp_rdy=1 in any state) and discarded, clearing drop_pend. CMD holds cmd_val low while drop_pend=1.
- Undefined: no counter, no drop_pend; waits indefinitely; o_ls_err reflects i_bus_rsp_err only; TIMEOUT_CYC unused.

## Structure
- Shared defines (cirno9_define.v): state encodings CIRNO_LSU_ST_IDLE/CMD/RSP/ACK (2-bit), CIRNO_LSU_TIMEOUT_DFLT.
- One sub-module: lsu_tmo (counter, expiry flag, drop_pend), instantiated only under CIRNO_LSU_TIMEOUT_EN.

## Test plan
- Store zero-wait: adr 0x8000_0006, wdat 0x1122_3344, wen 4'b1100, cmd_rdy=1, rsp next cycle → bus adr 0x8000_0004, wen 4'b1100, read 0; rdy cycle 3, err 0.
- Load with waits: cmd_rdy low 2 cycles, rsp 3 cycles later, dat 0xCAFE_BABE → cmd fields stable throughout; single rdy pulse with rdat 0xCAFE_BABE.
- Bus error: load, rsp_err=1, dat 0x1234_5678 → rdy with err=1; next load returns err 0.
- No-op: val with ren=0, wen=0 → no cmd_val; rdy cycle 1, rdat 0.
- Timeout (macro on, TIMEOUT_CYC=8): load, cmd accepted, no response → rdy+err at cycle 9. Late rsp 0xDEAD_0001 discarded. Following load's cmd_val waits for it, then returns its own 0x0000_00A5.
- Reset mid-RSP: rst_n low 1 cycle → all outputs 0, IDLE; fresh load completes normally.
